// File: rtl/pc_nzp_pkg.sv
// Shared constants and the reconvergence-stack entry layout for the SIMT PC/NZP unit.
package pc_nzp_pkg;

  localparam logic [2:0] CORE_STATE_EXECUTE = 3'b101;
  localparam logic [2:0] CORE_STATE_UPDATE  = 3'b110;

  localparam int unsigned NZP_N = 2;
  localparam int unsigned NZP_Z = 1;
  localparam int unsigned NZP_P = 0;
  localparam int unsigned NZP_W = 3;

  localparam int unsigned DEF_PC_WIDTH = 8;
  localparam int unsigned DEF_THREADS  = 4;

  // Entry layout at default widths; the top builds the same layout at its own widths.
  typedef struct packed {
    logic [DEF_PC_WIDTH-1:0] reconv;
    logic [DEF_PC_WIDTH-1:0] alt_pc;
    logic [DEF_THREADS-1:0]  alt_mask;
    logic [DEF_THREADS-1:0]  saved_mask;
    logic                    phase;
  } simt_entry_t;

endpackage

// File: rtl/pc_nzp_simt_if.sv
// Control/result bundle between the scheduler side and the SIMT PC/NZP unit.
interface pc_nzp_simt_if
  import pc_nzp_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned THREADS     = 4,
  parameter int unsigned STACK_DEPTH = 4
) ();

  localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);

  logic                          enable;
  logic [2:0]                    core_state;
  logic [PC_WIDTH-1:0]           current_pc;
  logic [THREADS*DATA_WIDTH-1:0] alu_out;
  logic [PC_WIDTH-1:0]           imm8;
  logic [PC_WIDTH-1:0]           reconv_pc;
  logic [2:0]                    decoded_nzp;
  logic                          nzp_write_enable;
  logic                          next_pc_mux;

  logic [PC_WIDTH-1:0]           next_pc;
  logic [THREADS-1:0]            active_mask;
  logic [THREADS*NZP_W-1:0]      nzp_flags;
  logic [DEPTH_W-1:0]            stack_depth;
  logic                          stack_overflow;

  modport master (
    output enable, core_state, current_pc, alu_out, imm8, reconv_pc,
           decoded_nzp, nzp_write_enable, next_pc_mux,
    input  next_pc, active_mask, nzp_flags, stack_depth, stack_overflow
  );

  modport slave (
    input  enable, core_state, current_pc, alu_out, imm8, reconv_pc,
           decoded_nzp, nzp_write_enable, next_pc_mux,
    output next_pc, active_mask, nzp_flags, stack_depth, stack_overflow
  );

endinterface

// File: rtl/pc_nzp_simt_stack.sv
// Reconvergence LIFO: push, pop or rewrite of the top entry, at most one per cycle.
module simt_stack
  import pc_nzp_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned DEPTH_W = $clog2(DEPTH + 1),
  parameter type         entry_t = simt_entry_t
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic               upd,
  input  entry_t             push_data,
  input  entry_t             upd_data,
  output entry_t             top,
  output logic               full,
  output logic               empty,
  output logic [DEPTH_W-1:0] depth
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [IDX_W-1:0]   top_idx, wr_idx;

  assign top_idx = IDX_W'(depth_q - DEPTH_W'(1));
  assign wr_idx  = IDX_W'(depth_q);
  assign empty   = (depth_q == '0);
  assign full    = (depth_q == DEPTH_W'(DEPTH));
  assign depth   = depth_q;
  assign top     = empty ? entry_t'('0) : mem_q[top_idx];

  // Full/empty guards keep depth inside [0, DEPTH] whatever the caller asks for.
  always_comb begin
    mem_d   = mem_q;
    depth_d = depth_q;
    if (push && !full) begin
      mem_d[wr_idx] = push_data;
      depth_d       = depth_q + DEPTH_W'(1);
    end else if (pop && !empty) begin
      depth_d = depth_q - DEPTH_W'(1);
    end else if (upd && !empty) begin
      mem_d[top_idx] = upd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      depth_q <= '0;
      mem_q   <= '{default: '0};
    end else begin
      depth_q <= depth_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/pc_nzp_simt.sv
// Per-block PC and per-thread NZP unit; branch divergence and the reconvergence
// stack exist only when PC_NZP_SIMT_DIVERGENCE_EN is defined (uniform branches otherwise).
module pc_nzp_simt
  import pc_nzp_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned THREADS     = 4,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  pc_nzp_simt_if.slave bus
);

  localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);

  logic [PC_WIDTH-1:0]             next_pc_q, next_pc_d;
  logic [THREADS-1:0]              active_mask_q, active_mask_d;
  logic [THREADS-1:0][NZP_W-1:0]   nzp_q, nzp_d;
  logic [PC_WIDTH-1:0]             seq_pc, cand;
  logic [THREADS-1:0]              taken;
  logic                            is_exec, is_update;

  assign is_exec   = bus.enable && (bus.core_state == CORE_STATE_EXECUTE);
  assign is_update = bus.enable && (bus.core_state == CORE_STATE_UPDATE) && bus.nzp_write_enable;
  assign seq_pc    = bus.current_pc + PC_WIDTH'(1);

  always_comb begin
    taken = '0;
    for (int t = 0; t < THREADS; t++) begin
      taken[t] = active_mask_q[t] & (|(nzp_q[t] & bus.decoded_nzp));
    end
  end

  // Only active threads latch their CMP result.
  always_comb begin
    nzp_d = nzp_q;
    if (is_update) begin
      for (int t = 0; t < THREADS; t++) begin
        if (active_mask_q[t]) nzp_d[t] = bus.alu_out[t*DATA_WIDTH +: NZP_W];
      end
    end
  end

`ifdef PC_NZP_SIMT_DIVERGENCE_EN
  typedef struct packed {
    logic [PC_WIDTH-1:0] reconv;
    logic [PC_WIDTH-1:0] alt_pc;
    logic [THREADS-1:0]  alt_mask;
    logic [THREADS-1:0]  saved_mask;
    logic                phase;
  } entry_t;

  entry_t             push_data, upd_data, top;
  logic               push, pop, upd, full, empty, diverge;
  logic [DEPTH_W-1:0] depth;
  logic               stack_overflow_q, stack_overflow_d;

  simt_stack #(
    .DEPTH   (STACK_DEPTH),
    .DEPTH_W (DEPTH_W),
    .entry_t (entry_t)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .upd       (upd),
    .push_data (push_data),
    .upd_data  (upd_data),
    .top       (top),
    .full      (full),
    .empty     (empty),
    .depth     (depth)
  );

  // Branch resolution; a split with no room left is forced down the taken path.
  always_comb begin
    cand             = seq_pc;
    diverge          = 1'b0;
    stack_overflow_d = stack_overflow_q;
    if (is_exec && bus.next_pc_mux && (taken != '0)) begin
      if (taken == active_mask_q) begin
        cand = bus.imm8;
      end else if (!full) begin
        diverge = 1'b1;
      end else begin
        cand             = bus.imm8;
        stack_overflow_d = 1'b1;
      end
    end
  end

  // Divergence pushes; otherwise hitting the top reconv PC runs the alternate path, then pops.
  always_comb begin
    next_pc_d           = next_pc_q;
    active_mask_d       = active_mask_q;
    push                = 1'b0;
    pop                 = 1'b0;
    upd                 = 1'b0;
    push_data.reconv    = bus.reconv_pc;
    push_data.alt_pc    = seq_pc;
    push_data.alt_mask  = active_mask_q & ~taken;
    push_data.saved_mask = active_mask_q;
    push_data.phase     = 1'b0;
    upd_data            = top;
    upd_data.phase      = 1'b1;
    if (is_exec) begin
      if (diverge) begin
        push          = 1'b1;
        active_mask_d = taken;
        next_pc_d     = bus.imm8;
      end else if (!empty && (cand == top.reconv)) begin
        if (!top.phase) begin
          upd           = 1'b1;
          next_pc_d     = top.alt_pc;
          active_mask_d = top.alt_mask;
        end else begin
          pop           = 1'b1;
          next_pc_d     = top.reconv;
          active_mask_d = top.saved_mask;
        end
      end else begin
        next_pc_d = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) stack_overflow_q <= 1'b0;
    else       stack_overflow_q <= stack_overflow_d;
  end

  assign bus.stack_depth    = depth;
  assign bus.stack_overflow = stack_overflow_q;
`else
  // Uniform branch: any taken active thread redirects the whole block.
  always_comb begin
    cand          = seq_pc;
    next_pc_d     = next_pc_q;
    active_mask_d = active_mask_q;
    if (is_exec) begin
      if (bus.next_pc_mux && (|taken)) cand = bus.imm8;
      next_pc_d = cand;
    end
  end

  assign bus.stack_depth    = DEPTH_W'(0);
  assign bus.stack_overflow = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      next_pc_q     <= '0;
      active_mask_q <= '1;
      nzp_q         <= '0;
    end else begin
      next_pc_q     <= next_pc_d;
      active_mask_q <= active_mask_d;
      nzp_q         <= nzp_d;
    end
  end

  assign bus.next_pc     = next_pc_q;
  assign bus.active_mask = active_mask_q;
  assign bus.nzp_flags   = nzp_q;

endmodule

// File: doc/pc_nzp_simt.md
# pc_nzp_simt

Per-block program-counter and condition-flag unit with divergence handling. It is the parametrised successor of the single-PC/NZP unit. It holds per-thread NZP flags and an active-thread mask, and resolves BRn branches per thread. When a branch splits the threads, it serialises the two paths through a reconvergence stack. It sits beside the scheduler and is sequenced by `core_state` (EXECUTE computes the next PC, UPDATE writes NZP).

## Interface
- `PC_WIDTH`, 8, program counter and branch-target width
- `DATA_WIDTH`, 8, per-thread ALU result width (≥3)
- `THREADS`, 4, threads per block (1..32)
- `STACK_DEPTH`, 4, reconvergence stack entries (≥1)
- `clk` in 1: the single clock. Reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high. Clears all state.
- `enable` in 1: block active. When low, all state holds.
- `core_state` in 3: scheduler state. 3'b101 = EXECUTE, 3'b110 = UPDATE.
- `current_pc` in PC_WIDTH: PC of the instruction in flight.
- `alu_out` in THREADS*DATA_WIDTH: thread t occupies `[t*DATA_WIDTH +: DATA_WIDTH]`. Bits [2:0] carry the CMP result {N,Z,P}.
- `imm8` in PC_WIDTH: branch target.
- `reconv_pc` in PC_WIDTH: reconvergence PC decoded with the branch.
- `decoded_nzp` in 3: branch condition mask {N,Z,P}.
- `nzp_write_enable` in 1: the instruction writes NZP.
- `next_pc_mux` in 1: 1 = branch instruction, 0 = sequential.
- `next_pc` out PC_WIDTH: registered next PC.
- `active_mask` out THREADS: threads currently executing.
- `nzp_flags` out THREADS*3: per-thread {N,Z,P}.
- `stack_depth` out clog2(STACK_DEPTH+1): current stack occupancy.
- `stack_overflow` out 1: sticky error flag.

## Operation
- The state machine is driven externally by `core_state`. The block acts only when `enable` is high. Other states hold.
- **UPDATE with `nzp_write_enable` set:** for each thread t with `active_mask[t]`=1, `nzp[t] <= alu_out_t[2:0]`. Inactive threads keep their flags.
- **EXECUTE:**
  - Sequential (`next_pc_mux`=0): candidate = `current_pc+1`, modulo 2^PC_WIDTH (wraps).
  - Branch: `taken[t] = active[t] & |(nzp[t] & decoded_nzp)`.
    - All active threads taken: candidate = `imm8`.
    - No active thread taken: candidate = `current_pc+1`.
    - Mixed, with stack not full (divergence):
      - Push {reconv=`reconv_pc`, alt_pc=`current_pc+1`, alt_mask=active&~taken, saved_mask=active, phase=0}.
      - `active_mask <= taken`; `next_pc <= imm8`.
    - Mixed, with stack full: no push. Treat as all taken (`next_pc <= imm8`, mask unchanged) and set `stack_overflow`.
  - Reconvergence, when there is no divergence this cycle, the stack is non-empty and candidate == top.reconv:
    - phase 0: `next_pc <= top.alt_pc`, `active_mask <= top.alt_mask`, set top.phase=1.
    - phase 1: pop, `active_mask <= top.saved_mask`, `next_pc <= top.reconv`.
  - Otherwise `next_pc <= candidate`.
- At most one stack operation per cycle. Divergence has priority over reconvergence.
- Nested divergence is supported up to `STACK_DEPTH`.

## Timing
- `next_pc`, `active_mask`, stack and flags update on the rising `clk` edge ending the EXECUTE or UPDATE cycle. Latency is 1 cycle.
- `nzp_flags` written in UPDATE are visible for the next EXECUTE.
- Reset values:
  - `next_pc`=0
  - `active_mask`=all ones
  - `nzp_flags`=0
  - `stack_depth`=0
  - `stack_overflow`=0
- Reset mid-divergence discards all stack entries in that same cycle.
- `reset` has priority over `enable`.
- `stack_overflow` clears only on reset.
- `stack_depth` never exceeds STACK_DEPTH and never underflows. A pop is only possible when non-empty.

## Configuration
- `PC_NZP_SIMT_DIVERGENCE_EN` defined: stack and divergence logic as above.
- Undefined:
  - Branches are uniform: candidate = `imm8` if any active thread is taken.
  - No stack is instantiated.
  - `active_mask` stays all ones (except after reset, still all ones).
  - `stack_depth`=0 and `stack_overflow`=0, tied off.

## Structure
- Package `pc_nzp_pkg`:
  - `CORE_STATE_EXECUTE`=3'b101, `CORE_STATE_UPDATE`=3'b110.
  - NZP bit indices `NZP_N`=2, `NZP_Z`=1, `NZP_P`=0.
  - Stack entry struct (reconv, alt_pc, alt_mask, saved_mask, phase).
- One sub-module: `simt_stack`, a parametrised LIFO with push, pop and top-field update, exposing full/empty/depth. It is instantiated only under the macro.

## Test plan
- **Reset:** hold `reset` 1 cycle with default params -> `next_pc`=0, `active_mask`=4'b1111, `nzp_flags`=0, `stack_depth`=0.
- **Uniform branch:**
  - UPDATE with all `alu_out[2:0]`=3'b001, then EXECUTE with `current_pc`=3, `decoded_nzp`=3'b001, `imm8`=9 -> `next_pc`=9, mask unchanged.
  - Repeat with `decoded_nzp`=3'b100 -> `next_pc`=4.
- **Divergence:**
  - Setup: threads 0,1 P and threads 2,3 Z. Branch at pc 3, `decoded_nzp`=001, `imm8`=9, `reconv_pc`=12.
  - EXECUTE at pc 3 -> `next_pc`=9, mask=0011, depth=1.
  - EXECUTE sequential at pc 11 -> `next_pc`=4, mask=1100.
  - EXECUTE sequential at pc 11 again -> `next_pc`=12, mask=1111, depth=0.
- **Overflow:** with `STACK_DEPTH`=1, issue two nested divergent branches -> depth=1 and `stack_overflow`=1. The second branch goes to `imm8` with the mask unchanged.
- **Wrap and hold:**
  - `current_pc`=255, sequential -> `next_pc`=0.
  - With `enable`=0, EXECUTE and UPDATE change nothing.
- **Mid-op reset:** reset while depth=2 -> depth=0, mask=1111 on the next cycle.
